// File: rtl/fifo_rd_unpack.sv
// rtl/fifo_rd_unpack.sv - FIFO read-side unpacker: wide FIFO words out as narrow beats
// Two word slots plus a one-cycle read-in-flight flag keep the beat stream gap-free.
module fifo_rd_unpack #(
    parameter int RD_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                                            rd_clk,
    input  logic                                            rd_rst,
    input  logic                                            fifo_empty,
    output logic                                            rd_en,
    input  logic [RD_WIDTH-1:0]                             rd_data,
    input  logic                                            flush,
    output logic [OUT_WIDTH-1:0]                            out_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [$clog2(2*(RD_WIDTH/OUT_WIDTH)+1)-1:0]     beat_count
);
    localparam int RATIO = RD_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CNT_W = $clog2(2*RATIO+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO-1);
    localparam logic [CNT_W-1:0] RATIO_C  = CNT_W'(RATIO);

    logic [RD_WIDTH-1:0]  r_cur_word;
    logic                 r_cur_valid;
    logic [IDX_W-1:0]     r_idx;
    logic [RD_WIDTH-1:0]  r_nxt_word;
    logic                 r_nxt_valid;
    logic                 r_inflight;
    logic [CNT_W-1:0]     r_beat_count;

    logic [RD_WIDTH-1:0]  w_cur_word_n;
    logic                 w_cur_valid_n;
    logic [IDX_W-1:0]     w_idx_n;
    logic [RD_WIDTH-1:0]  w_nxt_word_n;
    logic                 w_nxt_valid_n;
    logic                 w_take;
    logic [CNT_W-1:0]     w_cnt_n;
    logic [1:0]           w_free;
    logic                 w_xfer;
    logic [OUT_WIDTH-1:0] w_beats [RATIO];

    for (genvar g = 0; g < RATIO; g++) begin : g_slice
        if (MSB_FIRST != 0) begin : g_msb
            assign w_beats[g] = r_cur_word[RD_WIDTH-1-g*OUT_WIDTH -: OUT_WIDTH];
        end else begin : g_lsb
            assign w_beats[g] = r_cur_word[g*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // A read in flight already owns one of the free slots.
    assign w_free    = {1'b0, ~r_cur_valid} + {1'b0, ~r_nxt_valid};
    assign rd_en     = !fifo_empty && !flush && !rd_rst && (w_free > {1'b0, r_inflight});
    assign out_valid = r_cur_valid && !rd_rst;
    assign out_data  = out_valid ? w_beats[r_idx] : '0;
    assign w_xfer    = out_valid && out_ready;
    assign beat_count = r_beat_count;

    always_comb begin
        w_cur_word_n  = r_cur_word;
        w_cur_valid_n = r_cur_valid;
        w_idx_n       = r_idx;
        w_nxt_word_n  = r_nxt_word;
        w_nxt_valid_n = r_nxt_valid;
        w_take        = r_inflight;
        if (w_xfer) begin
            if (r_idx != LAST_IDX) begin
                w_idx_n = r_idx + 1'b1;
            end else begin
                w_idx_n = '0;
                if (r_nxt_valid) begin
                    w_cur_word_n  = r_nxt_word;
                    w_nxt_valid_n = 1'b0;
                end else if (r_inflight) begin
                    w_cur_word_n = rd_data;
                    w_take       = 1'b0;
                end else begin
                    w_cur_valid_n = 1'b0;
                end
            end
        end
        // Arriving word lands in whichever slot is empty after this cycle's pop.
        if (w_take) begin
            if (!w_cur_valid_n) begin
                w_cur_word_n  = rd_data;
                w_cur_valid_n = 1'b1;
                w_idx_n       = '0;
            end else begin
                w_nxt_word_n  = rd_data;
                w_nxt_valid_n = 1'b1;
            end
        end
        if (flush) begin
            w_cur_valid_n = 1'b0;
            w_nxt_valid_n = 1'b0;
            w_idx_n       = '0;
        end
        w_cnt_n = (w_cur_valid_n ? (RATIO_C - CNT_W'(w_idx_n)) : '0)
                + (w_nxt_valid_n ? RATIO_C : '0);
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_cur_word   <= '0;
            r_cur_valid  <= 1'b0;
            r_idx        <= '0;
            r_nxt_word   <= '0;
            r_nxt_valid  <= 1'b0;
            r_inflight   <= 1'b0;
            r_beat_count <= '0;
        end else begin
            r_cur_word   <= w_cur_word_n;
            r_cur_valid  <= w_cur_valid_n;
            r_idx        <= w_idx_n;
            r_nxt_word   <= w_nxt_word_n;
            r_nxt_valid  <= w_nxt_valid_n;
            r_inflight   <= rd_en;
            r_beat_count <= w_cnt_n;
        end
    end
endmodule

// File: tb/tb_fifo_rd_unpack.sv
// tb/tb_fifo_rd_unpack.sv - scoreboard bench for fifo_rd_unpack, LSB-first and MSB-first instances
module tb_fifo_rd_unpack;
    logic        clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] rd_data = 32'hDEADBEEF;

    logic       rd_en_l, rd_en_m, out_valid_l, out_valid_m;
    logic [7:0] out_data_l, out_data_m;
    logic [3:0] beat_count_l, beat_count_m;

    logic [31:0] fifo_q [$];
    logic [7:0]  exp_l [$];
    logic [7:0]  exp_m [$];

    int n_tests = 0;
    int n_fail = 0;
    int rd_cnt_l = 0;
    int rd_cnt_m = 0;
    int beats_l = 0;

    always #5 clk = ~clk;

    fifo_rd_unpack #(.RD_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) u_dut_lsb (
        .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .rd_en(rd_en_l),
        .rd_data(rd_data), .flush(flush), .out_data(out_data_l), .out_valid(out_valid_l),
        .out_ready(out_ready), .beat_count(beat_count_l)
    );

    fifo_rd_unpack #(.RD_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) u_dut_msb (
        .rd_clk(clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .rd_en(rd_en_m),
        .rd_data(rd_data), .flush(flush), .out_data(out_data_m), .out_valid(out_valid_m),
        .out_ready(out_ready), .beat_count(beat_count_m)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: one-cycle read latency, empty flag registered.
    always @(posedge clk) begin
        if (rd_en_l) begin
            if (fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
        end else begin
            rd_data <= 32'hDEADBEEF;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (!rd_rst && !flush) begin
            if (out_valid_l && out_ready) begin
                beats_l++;
                if (exp_l.size() == 0) check("lsb_extra_beat", {56'd0, out_data_l}, 64'hFFFF);
                else check("lsb_beat", {56'd0, out_data_l}, {56'd0, exp_l.pop_front()});
            end
            if (out_valid_m && out_ready) begin
                if (exp_m.size() == 0) check("msb_extra_beat", {56'd0, out_data_m}, 64'hFFFF);
                else check("msb_beat", {56'd0, out_data_m}, {56'd0, exp_m.pop_front()});
            end
            if (rd_en_l) begin
                rd_cnt_l++;
                check("rd_en_while_empty", {63'd0, fifo_empty}, 64'd0);
            end
            if (rd_en_m) rd_cnt_m++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) exp_l.push_back(t[i*8 +: 8]);
        for (int i = 0; i < 4; i++) exp_m.push_back(t[31-i*8 -: 8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        push_beats(w);
    endtask

    task automatic rebuild();
        exp_l.delete();
        exp_m.delete();
        foreach (fifo_q[i]) push_beats(fifo_q[i]);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_l.size() != 0 || exp_m.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check(tag, {63'd0, exp_l.size() == 0 && exp_m.size() == 0}, 64'd1);
    endtask

    task automatic wait_rd_en(input string tag);
        int n;
        n = 0;
        while (!rd_en_l && n < 20) begin
            tick();
            n++;
        end
        check(tag, {63'd0, rd_en_l}, 64'd1);
    endtask

    initial begin
        int base_l, base_m, n;
        repeat (3) tick();
        check("rst_rd_en", {63'd0, rd_en_l}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid_l}, 64'd0);
        check("rst_out_data", {56'd0, out_data_l}, 64'd0);
        check("rst_beat_count", {60'd0, beat_count_l}, 64'd0);
        rd_rst = 1'b0;
        repeat (3) tick();
        check("idle_beat_count", {60'd0, beat_count_m}, 64'd0);
        check("idle_out_valid", {63'd0, out_valid_m}, 64'd0);

        // Two words streamed: latency, no bubble, exactly two reads
        out_ready = 1'b1;
        base_l = rd_cnt_l; base_m = rd_cnt_m;
        push_word(32'h03020100);
        push_word(32'h07060504);
        wait_rd_en("seq_rd_en_seen");
        n = 0;
        while (!out_valid_l && n < 10) begin
            tick();
            n++;
        end
        check("first_latency", n, 2);
        for (int i = 0; i < 8; i++) begin
            check("no_bubble", {63'd0, out_valid_l}, 64'd1);
            tick();
        end
        wait_drain("seq_drain", 20);
        repeat (3) tick();
        check("seq_rd_count_lsb", rd_cnt_l - base_l, 2);
        check("seq_rd_count_msb", rd_cnt_m - base_m, 2);

        // MSB-first slicing
        push_word(32'hA1B2C3D4);
        wait_drain("msb_drain", 30);
        repeat (3) tick();

        // Stalled sink: reads stop once both slots are full
        out_ready = 1'b0;
        base_l = rd_cnt_l; base_m = rd_cnt_m;
        for (int i = 0; i < 6; i++) push_word(32'h10203040 + 32'h01010101 * i);
        repeat (20) tick();
        check("stall_rd_count_lsb", rd_cnt_l - base_l, 2);
        check("stall_rd_count_msb", rd_cnt_m - base_m, 2);
        check("stall_beat_count_lsb", {60'd0, beat_count_l}, 64'd8);
        check("stall_beat_count_msb", {60'd0, beat_count_m}, 64'd8);
        check("stall_rd_en", {63'd0, rd_en_l}, 64'd0);
        out_ready = 1'b1;
        wait_drain("stall_drain", 60);
        repeat (3) tick();

        // Sink toggling ready every cycle
        for (int i = 0; i < 4; i++) push_word($urandom);
        n = 0;
        while ((exp_l.size() != 0 || exp_m.size() != 0) && n < 200) begin
            out_ready = ~out_ready;
            tick();
            n++;
        end
        check("toggle_drain", {63'd0, exp_l.size() == 0 && exp_m.size() == 0}, 64'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        check("idle2_beat_count", {60'd0, beat_count_l}, 64'd0);

        // Flush one cycle after the read drops the returning word
        push_word(32'h55667788);
        wait_rd_en("flush_rd_en_seen");
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rebuild();
        check("flush_out_valid", {63'd0, out_valid_l}, 64'd0);
        check("flush_beat_count", {60'd0, beat_count_l}, 64'd0);
        repeat (5) tick();
        check("flush_no_return", {63'd0, out_valid_m}, 64'd0);

        // Reset mid-word drops the rest, next beat is from the following FIFO word
        push_word(32'h1A2B3C4D);
        push_word(32'h5E6F7081);
        push_word(32'h92A3B4C5);
        base_l = beats_l;
        n = 0;
        while (beats_l - base_l < 2 && n < 30) begin
            tick();
            n++;
        end
        check("mid_word_two_beats", beats_l - base_l, 2);
        rd_rst = 1'b1;
        #1;
        check("midrst_rd_en", {63'd0, rd_en_l}, 64'd0);
        check("midrst_out_valid", {63'd0, out_valid_l}, 64'd0);
        check("midrst_out_data", {56'd0, out_data_m}, 64'd0);
        tick();
        rd_rst = 1'b0;
        rebuild();
        check("midrst_fifo_left", fifo_q.size(), 1);
        wait_drain("midrst_drain", 30);
        repeat (4) tick();
        check("final_beat_count", {60'd0, beat_count_m}, 64'd0);
        check("final_out_valid", {63'd0, out_valid_l}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fifo_rd_unpack.md
FIFO_RD_UNPACK -- requirements
Module: fifo_rd_unpack

Interface
REQ-001 SHALL have parameter RD_WIDTH, default 32, the FIFO read-port word width.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, the output beat width; RD_WIDTH SHALL be an integer multiple of OUT_WIDTH, with RATIO = RD_WIDTH/OUT_WIDTH.
REQ-003 SHALL have parameter MSB_FIRST, default 1, selecting whether the first beat is taken from the upper or the lower slice of the word.
REQ-004 SHALL have port rd_clk, input, 1 bit: the single clock, shared with the FIFO read port. All logic SHALL run on its rising edge.
REQ-005 SHALL have port rd_rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 SHALL have port fifo_empty, input, 1 bit: the FIFO read-side empty flag.
REQ-007 SHALL have port rd_en, output, 1 bit: the FIFO read enable.
REQ-008 SHALL have port rd_data, input, RD_WIDTH bits: the FIFO read data, valid exactly one cycle after a rd_en cycle.
REQ-009 SHALL have port flush, input, 1 bit: a synchronous discard of all buffered data.
REQ-010 SHALL have port out_data, output, OUT_WIDTH bits: the serialized beat.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream sink accepts the beat.
REQ-013 SHALL have port beat_count, output, clog2(2*RATIO+1) bits: the number of beats currently held internally.

Function
REQ-014 SHALL hold two word slots: the current slot (word, valid flag, beat index 0..RATIO-1) and the next slot (word, valid flag). It SHALL also keep one in-flight flag that tracks a read issued last cycle.
REQ-015 SHALL assert rd_en combinationally when all of the following hold: fifo_empty=0, flush=0, rd_rst=0, and the free slots, counted as (!cur_valid)+(!nxt_valid)-inflight, are greater than 0.
REQ-016 SHALL set inflight to the registered value of rd_en, and on the cycle inflight=1 SHALL capture rd_data into the current slot if it is empty after this cycle's pop, otherwise into the next slot.
REQ-017 SHALL drive out_valid=cur_valid. When MSB_FIRST=1, out_data SHALL be word[RD_WIDTH-1-idx*OUT_WIDTH -: OUT_WIDTH]; otherwise it SHALL be word[idx*OUT_WIDTH +: OUT_WIDTH].
REQ-018 A transfer SHALL occur on a cycle where out_valid=1 and out_ready=1. On a transfer the index SHALL increment. On a transfer at idx=RATIO-1, the current slot SHALL be refilled from the next slot if valid, or else from the arriving rd_data if inflight, or else become empty. The new idx SHALL be 0.
REQ-019 A continuous out_ready=1 with a never-empty FIFO SHALL produce one beat per cycle with no bubble at word boundaries.
REQ-020 While out_valid=1 and out_ready=0, out_data and idx SHALL stay stable.
REQ-021 Latency SHALL be 2 cycles from the first rd_en to out_valid=1 with a fresh, empty block.
REQ-022 flush=1 SHALL, on that edge, clear both valid flags, idx and inflight, and SHALL suppress rd_en. Data returning from a read issued the cycle before the flush SHALL be dropped.
REQ-023 A flush and a transfer on the same edge SHALL act as flush only.
REQ-024 beat_count SHALL equal (cur_valid ? RATIO-idx : 0) + (nxt_valid ? RATIO : 0), registered. It SHALL be 0 when idle and SHALL never exceed 2*RATIO.
REQ-025 The block SHALL never issue a read that would overflow the slots and SHALL never assert rd_en while fifo_empty=1.

Reset
REQ-026 While rd_rst=1, on each edge the block SHALL clear cur_valid, nxt_valid, inflight, idx and beat_count to 0.
REQ-027 During reset rd_en SHALL be 0, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-028 A reset asserted mid-word SHALL discard the remaining beats. The first beat after reset release SHALL come from a newly read word.

Verification
REQ-029 With defaults and a FIFO preloaded with words 0x03020100 and 0x07060504 (MSB_FIRST=0) and out_ready=1, out_data SHALL be 00,01,02,03,04,05,06,07 on consecutive cycles, and rd_en SHALL be 1 for exactly 2 cycles.
REQ-030 With MSB_FIRST=1 and the word 0xA1B2C3D4, the beats SHALL be A1,B2,C3,D4.
REQ-031 With out_ready=0 and a deep FIFO, exactly 2 reads SHALL be issued, beat_count SHALL saturate at 8 and rd_en SHALL then stay 0. On releasing out_ready, all 8 beats SHALL emerge in order.
REQ-032 With out_ready toggling 1,0,1,0, each beat SHALL be held while stalled, with no duplicates or drops over 16 beats.
REQ-033 flush asserted one cycle after rd_en SHALL give out_valid=0 the next cycle and beat_count=0. The returning word SHALL not appear.
REQ-034 rd_rst pulsed after beat 2 of a word SHALL drop beats 3-4. The next beats SHALL start at beat 1 of the following FIFO word.
